muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/muldiv_div_iter.sv | 45 ++++
 rtl/muldiv_unit.sv | 118 +++++++++++
 tb/tb_muldiv_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants, state type and helpers for the RV32M multiply/divide unit.
package muldiv_pkg;
  localparam int XLEN  = 32;
  localparam int CNT_W = 5;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/muldiv_div_iter.sv
// muldiv_div_iter: radix-2 restoring divider on magnitudes; quo_o/rem_o are the
// sign-corrected results of the step taking place this cycle.
module muldiv_div_iter
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            sgn_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o
);
  logic [XLEN-1:0] quo_q, rem_q, dvs_q, quo_d, rem_d;
  logic            qneg_q, rneg_q;
  logic [XLEN:0]   sh, diff;
  always_comb begin
    sh    = {rem_q, quo_q[XLEN-1]};
    diff  = sh - {1'b0, dvs_q};
    rem_d = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
    quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
    quo_o = qneg_q ? -quo_d : quo_d;
    rem_o = rneg_q ? -rem_d : rem_d;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (load_i) begin
      quo_q  <= mag(dividend_i, sgn_i);
      rem_q  <= '0;
      dvs_q  <= mag(divisor_i, sgn_i);
      qneg_q <= sgn_i && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
      rneg_q <= sgn_i && dividend_i[XLEN-1];
    end else if (step_i) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with valid/ready request and response.
// Division ops are built only with MULDIV_DIV_EN defined; otherwise they report resp_illegal.
module muldiv_unit #(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [4:0]      req_rd,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [4:0]      resp_rd,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_illegal
);
  import muldiv_pkg::*;
  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] prod_q, prod_d, prod_s;
  logic [XLEN-1:0]   mcand_q, res_q, mul_fin, fin, fast_res;
  logic [XLEN:0]     sum;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic              neg_q, rdy_q, vld_q, ill_q;
  logic              a_sgn, b_sgn, fast, ill, accept;
  assign accept = req_valid && rdy_q;
`ifdef MULDIV_DIV_EN
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  logic [XLEN-1:0] div_quo, div_rem;
  muldiv_div_iter u_div (
    .clk        (clk),
    .reset      (reset),
    .load_i     (accept),
    .step_i     (state_q == BUSY),
    .sgn_i      (!req_funct3[0]),
    .dividend_i (req_rs1),
    .divisor_i  (req_rs2),
    .quo_o      (div_quo),
    .rem_o      (div_rem)
  );
`endif
  // Shift-add on magnitudes: low half holds the multiplier, high half accumulates.
  always_comb begin
    a_sgn   = req_funct3 == F3_MULH || req_funct3 == F3_MULHSU;
    b_sgn   = req_funct3 == F3_MULH;
    sum     = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_d  = {sum, prod_q[XLEN-1:1]};
    prod_s  = neg_q ? -prod_d : prod_d;
    mul_fin = f3_q == F3_MUL ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
    ill      = 1'b0;
    fast     = req_funct3[2] && (req_rs2 == '0 || (!req_funct3[0] && req_rs1 == MIN && &req_rs2));
    fast_res = req_rs2 == '0 ? (req_funct3[1] ? req_rs1 : '1) : (req_funct3[1] ? '0 : MIN);
    fin      = f3_q[2] ? (f3_q[1] ? div_rem : div_quo) : mul_fin;
`else
    ill      = req_funct3[2];
    fast     = ill;
    fast_res = '0;
    fin      = mul_fin;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      res_q   <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          f3_q    <= req_funct3;
          rd_q    <= req_rd;
          cnt_q   <= '1;
          mcand_q <= mag(req_rs1, a_sgn);
          prod_q  <= {{XLEN{1'b0}}, mag(req_rs2, b_sgn)};
          neg_q   <= (a_sgn && req_rs1[XLEN-1]) ^ (b_sgn && req_rs2[XLEN-1]);
          rdy_q   <= 1'b0;
          vld_q   <= fast;
          ill_q   <= ill;
          res_q   <= fast_res;
          state_q <= fast ? DONE : BUSY;
        end
        BUSY: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_q <= DONE;
            vld_q   <= 1'b1;
            res_q   <= fin;
          end
        end
        DONE: if (resp_ready) begin
          state_q <= IDLE;
          rdy_q   <= 1'b1;
          vld_q   <= 1'b0;
          ill_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign req_ready    = rdy_q;
  assign resp_valid   = vld_q;
  assign resp_data    = res_q;
  assign resp_rd      = rd_q;
  assign resp_illegal = ill_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven results/latency for all ops, plus backpressure and reset-abort sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  logic        clk = 1'b0, reset = 1'b1, req_valid = 1'b0, resp_ready = 1'b0;
  logic        req_ready, resp_valid, resp_illegal;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_rs1 = '0, req_rs2 = '0, resp_data;
  logic [4:0]  req_rd = '0, resp_rd;
  int          total = 0, bad = 0;
  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    int          lat;
  } vec_t;
  vec_t vt[22];
  muldiv_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .req_rd       (req_rd),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rd      (resp_rd),
    .resp_data    (resp_data),
    .resp_illegal (resp_illegal)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // lat counts clock edges starting with the accepting one, so a 1-cycle op reads 1.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 60) begin
      tick();
      lat++;
    end
  endtask
  task automatic run_op(input string tag, input vec_t v);
    logic [31:0] e_res = v.res;
    int          e_lat = v.lat;
    logic        e_ill = 1'b0;
    int          lat;
    if (!DIV_EN && v.f3[2]) begin
      e_res = '0;
      e_lat = 1;
      e_ill = 1'b1;
    end
    req_funct3 = v.f3;
    req_rs1    = v.a;
    req_rs2    = v.b;
    req_rd     = v.rd;
    req_valid  = 1'b1;
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    wait_resp(lat);
    check({tag, " latency"}, 32'(lat), 32'(e_lat));
    check({tag, " data"}, resp_data, e_res);
    check({tag, " rd"}, 32'(resp_rd), 32'(v.rd));
    check({tag, " illegal"}, 32'(resp_illegal), 32'(e_ill));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, " valid_low"}, 32'(resp_valid), 32'd0);
    check({tag, " ready_back"}, 32'(req_ready), 32'd1);
  endtask
  initial begin
    int lat;
    logic seen;
    vt[0]  = '{F3_MUL,    32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33};
    vt[1]  = '{F3_MULH,   32'h80000000,   32'h80000000, 5'd1,  32'h40000000, 33};
    vt[2]  = '{F3_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 33};
    vt[3]  = '{F3_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 33};
    vt[4]  = '{F3_MUL,    32'd3,          32'd4,        5'd0,  32'd12,       33};
    vt[5]  = '{F3_MULH,   32'hFFFFFFFF,   32'd2,        5'd31, 32'hFFFFFFFF, 33};
    vt[6]  = '{F3_MULHU,  32'h00010000,   32'h00010000, 5'd6,  32'd1,        33};
    vt[7]  = '{F3_MULHSU, 32'd2,          32'h80000000, 5'd7,  32'd1,        33};
    vt[8]  = '{F3_MUL,    32'h12345678,   32'd0,        5'd8,  32'd0,        33};
    vt[9]  = '{F3_MULH,   32'd7,          32'hFFFFFFFD, 5'd9,  32'hFFFFFFFF, 33};
    vt[10] = '{F3_DIV,    32'hFFFFFFF9,   32'd2,        5'd10, 32'hFFFFFFFD, 33};
    vt[11] = '{F3_REM,    32'hFFFFFFF9,   32'd2,        5'd11, 32'hFFFFFFFF, 33};
    vt[12] = '{F3_DIVU,   32'd100,        32'd0,        5'd12, 32'hFFFFFFFF, 1};
    vt[13] = '{F3_REM,    32'h80000000,   32'hFFFFFFFF, 5'd13, 32'd0,        1};
    vt[14] = '{F3_DIV,    32'h80000000,   32'hFFFFFFFF, 5'd14, 32'h80000000, 1};
    vt[15] = '{F3_REMU,   32'd100,        32'd0,        5'd15, 32'd100,      1};
    vt[16] = '{F3_DIVU,   32'hFFFFFFFF,   32'd16,       5'd16, 32'h0FFFFFFF, 33};
    vt[17] = '{F3_REMU,   32'd100,        32'd7,        5'd17, 32'd2,        33};
    vt[18] = '{F3_DIV,    32'd7,          32'hFFFFFFFE, 5'd18, 32'hFFFFFFFD, 33};
    vt[19] = '{F3_REM,    32'd7,          32'hFFFFFFFE, 5'd19, 32'd1,        33};
    vt[20] = '{F3_DIV,    32'd10,         32'd2,        5'd20, 32'd5,        33};
    vt[21] = '{F3_DIVU,   32'h80000000,   32'hFFFFFFFF, 5'd21, 32'd0,        33};
    repeat (3) tick();
    check("rst valid", 32'(resp_valid), 32'd0);
    check("rst data", resp_data, 32'd0);
    check("rst rd", 32'(resp_rd), 32'd0);
    check("rst illegal", 32'(resp_illegal), 32'd0);
    reset = 1'b0;
    check("rst ready", 32'(req_ready), 32'd1);
    tick();
    for (int i = 0; i < 22; i++) run_op($sformatf("v%0d", i), vt[i]);
    // Backpressure: result held for 10 cycles while a new request waits.
    req_funct3 = F3_MUL;
    req_rs1    = 32'h0000FFFF;
    req_rs2    = 32'h0000FFFF;
    req_rd     = 5'd9;
    req_valid  = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_resp(lat);
    check("bp latency", 32'(lat), 32'd33);
    check("bp data", resp_data, 32'hFFFE0001);
    req_funct3 = F3_MULHU;
    req_rs1    = 32'hFFFFFFFF;
    req_rs2    = 32'd2;
    req_rd     = 5'd3;
    req_valid  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("bp hold%0d valid", k), 32'(resp_valid), 32'd1);
      check($sformatf("bp hold%0d data", k), resp_data, 32'hFFFE0001);
      check($sformatf("bp hold%0d rd", k), 32'(resp_rd), 32'd9);
      check($sformatf("bp hold%0d ready", k), 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("bp release valid", 32'(resp_valid), 32'd0);
    check("bp release ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("bp accept ready", 32'(req_ready), 32'd0);
    wait_resp(lat);
    check("bp2 latency", 32'(lat), 32'd33);
    check("bp2 data", resp_data, 32'd1);
    check("bp2 rd", 32'(resp_rd), 32'd3);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    // Reset during BUSY aborts the operation.
    req_funct3 = F3_MUL;
    req_rs1    = 32'h1234;
    req_rs2    = 32'd5;
    req_rd     = 5'd4;
    req_valid  = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (12) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort ready", 32'(req_ready), 32'd1);
    check("abort data", resp_data, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      seen |= resp_valid;
    end
    check("abort no resp", 32'(seen), 32'd0);
    run_op("post_abort", '{F3_MUL, 32'd3, 32'd4, 5'd2, 32'd12, 33});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
